fetch_unit: RTL and testbench

Instruction fetch stage for the SISC datapath. It holds the program counter (PC) and the instruction register (IR), runs a req/valid handshake to instruction memory, and resolves branch instructions (BRA/BRR/BNE/BNR) against the status flags. It sits directly upstream of the control FSM and feeds it `opcode`/`mm`. The control FSM drives `fetch_start` in its fetch state and `br_eval` in its execute state.

---
 rtl/sisc_pkg.sv | 31 +++
 rtl/br_cond.sv | 32 +++
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// rtl/sisc_pkg.sv - shared SISC opcodes, instruction fields and fetch states
package sisc_pkg;

    // Opcode encodings (ir[31:28])
    localparam logic [3:0] NOOP   = 4'd0;
    localparam logic [3:0] LOD    = 4'd1;
    localparam logic [3:0] STR    = 4'd2;
    localparam logic [3:0] SWP    = 4'd3;
    localparam logic [3:0] BRA    = 4'd4;
    localparam logic [3:0] BRR    = 4'd5;
    localparam logic [3:0] BNE    = 4'd6;
    localparam logic [3:0] BNR    = 4'd7;
    localparam logic [3:0] ALU_OP = 4'd8;
    localparam logic [3:0] HLT    = 4'd15;

    // Instruction field positions
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int MM_MSB  = 27;
    localparam int MM_LSB  = 24;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    // Fetch sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/br_cond.sv
// rtl/br_cond.sv - branch condition decode against status flags
module br_cond
    import sisc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       taken,
    output logic       is_relative
);

    // BRA/BRR branch when any masked flag is set (mm==0 means always);
    // BNE/BNR branch when all masked flags are clear.
    always_comb begin
        taken       = 1'b0;
        is_relative = 1'b0;
        case (opcode)
            BRA: taken = (mm == 4'd0) || ((stat & mm) != 4'd0);
            BRR: begin
                taken       = (mm == 4'd0) || ((stat & mm) != 4'd0);
                is_relative = 1'b1;
            end
            BNE: taken = ((stat & mm) == 4'd0);
            BNR: begin
                taken       = ((stat & mm) == 4'd0);
                is_relative = 1'b1;
            end
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/IR fetch stage with imem handshake and branch resolve
module fetch_unit
    import sisc_pkg::*;
#(
    parameter int             AW       = 16,
    parameter int             DW       = 32,
    parameter logic [AW-1:0]  RESET_PC = '0,
    parameter int             TIMEOUT  = 15
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          fetch_start,
    input  logic          br_eval,
    input  logic [3:0]    stat,
    input  logic [DW-1:0] imem_rdata,
    input  logic          imem_valid,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    output logic [DW-1:0] ir,
    output logic [3:0]    opcode,
    output logic [3:0]    mm,
    output logic [AW-1:0] pc,
    output logic          fetch_done,
    output logic          br_taken,
    output logic          fetch_err
);

    // Last WAIT count value before giving up on the memory
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);

    fetch_state_t  state, state_d;
    logic [3:0]    cnt, cnt_d;
    logic [AW-1:0] pc_d, addr_d, imm_ext;
    logic [DW-1:0] ir_d;
    logic          req_d, done_d, taken_d, err_d;
    logic          br_take, br_rel;

    assign opcode  = ir[OPC_MSB:OPC_LSB];
    assign mm      = ir[MM_MSB:MM_LSB];
    assign imm_ext = AW'($signed(ir[IMM_MSB:IMM_LSB]));

    br_cond u_br_cond (
        .opcode      (opcode),
        .mm          (mm),
        .stat        (stat),
        .taken       (br_take),
        .is_relative (br_rel)
    );

    // Next-state and next-output logic; branch applies before a same-cycle fetch
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pc_d    = pc;
        ir_d    = ir;
        req_d   = imem_req;
        addr_d  = imem_addr;
        done_d  = 1'b0;
        taken_d = 1'b0;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                if (br_eval && br_take) begin
                    pc_d    = br_rel ? (pc + imm_ext) : imm_ext;
                    taken_d = 1'b1;
                end
                if (fetch_start) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                req_d   = 1'b1;
                addr_d  = pc;
                cnt_d   = 4'd0;
                state_d = WAIT;
            end
            WAIT: begin
                if (imem_valid) begin
                    ir_d    = imem_rdata;
                    pc_d    = pc + AW'(1);
                    done_d  = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else if (cnt == TO_LAST) begin
                    err_d   = 1'b1;
                    req_d   = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt + 4'd1;
                end
            end
            default: begin
                req_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any fetch in flight
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            pc         <= RESET_PC;
            ir         <= '0;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            fetch_done <= 1'b0;
            br_taken   <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            pc         <= pc_d;
            ir         <= ir_d;
            imem_req   <= req_d;
            imem_addr  <= addr_d;
            fetch_done <= done_d;
            br_taken   <= taken_d;
            fetch_err  <= err_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_f = 1'b0;
    logic          fetch_start = 1'b0;
    logic          br_eval = 1'b0;
    logic [3:0]    stat = 4'd0;
    logic [DW-1:0] imem_rdata = '0;
    logic          imem_valid = 1'b0;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] ir;
    logic [3:0]    opcode;
    logic [3:0]    mm;
    logic [AW-1:0] pc;
    logic          fetch_done;
    logic          br_taken;
    logic          fetch_err;

    fetch_unit #(
        .AW(AW), .DW(DW), .RESET_PC(16'h0000), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rst_f(rst_f), .fetch_start(fetch_start), .br_eval(br_eval),
        .stat(stat), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .imem_req(imem_req), .imem_addr(imem_addr), .ir(ir), .opcode(opcode),
        .mm(mm), .pc(pc), .fetch_done(fetch_done), .br_taken(br_taken),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int done_cyc = -100;
    int err_cnt = 0;
    int done_cnt = 0;
    int taken_cnt = 0;
    logic [AW-1:0] seen_addr = '0;
    bit chk_en = 1'b0;

    logic [15:0] exp_pc = 16'h0000;
    logic [31:0] exp_ir = 32'h0;
    logic        exp_req = 1'b0;
    logic [15:0] exp_addr = 16'h0;
    logic        exp_done = 1'b0;
    logic        exp_taken = 1'b0;
    logic        exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Branch outcome from the instruction-set rules
    function automatic bit model_taken(input logic [31:0] i, input logic [3:0] s);
        logic [3:0] op;
        logic [3:0] m;
        op = i[31:28];
        m  = i[27:24];
        if (op == 4'd4 || op == 4'd5) return (m == 4'd0) || ((s & m) != 4'd0);
        if (op == 4'd6 || op == 4'd7) return (s & m) == 4'd0;
        return 1'b0;
    endfunction

    function automatic logic [15:0] model_target(input logic [31:0] i, input logic [15:0] p);
        int t;
        if (i[31:28] == 4'd5 || i[31:28] == 4'd7) begin
            t = (int'(p) + int'(i[15:0])) % 65536;
            return t[15:0];
        end
        return i[15:0];
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Event recorders for literal checks
    always @(negedge clk) begin
        if (fetch_done) begin
            done_cyc <= cyc;
            done_cnt <= done_cnt + 1;
        end
        if (fetch_err) err_cnt <= err_cnt + 1;
        if (br_taken) taken_cnt <= taken_cnt + 1;
        if (imem_req) seen_addr <= imem_addr;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", 32'(pc), 32'(exp_pc));
            check("ir", ir, exp_ir);
            check("opcode", 32'(opcode), 32'(exp_ir[31:28]));
            check("mm", 32'(mm), 32'(exp_ir[27:24]));
            check("imem_req", 32'(imem_req), 32'(exp_req));
            check("fetch_done", 32'(fetch_done), 32'(exp_done));
            check("br_taken", 32'(br_taken), 32'(exp_taken));
            check("fetch_err", 32'(fetch_err), 32'(exp_err));
            if (exp_req) check("imem_addr", 32'(imem_addr), 32'(exp_addr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] data, input int delay, input bit give_valid,
                            input bit noise, output int lat);
        int t0;
        done_cyc = -100;
        t0 = cyc;
        fetch_start = 1'b1;
        imem_valid  = noise;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        fetch_start = 1'b0;
        imem_valid  = noise;
        br_eval     = noise;
        if (noise) fetch_start = 1'b1;
        step();
        imem_valid  = 1'b0;
        fetch_start = 1'b0;
        br_eval     = 1'b0;
        exp_req  = 1'b1;
        exp_addr = exp_pc;
        if (give_valid) begin
            for (int i = 0; i < delay; i++) begin
                fetch_start = noise;
                br_eval     = noise;
                step();
                fetch_start = 1'b0;
                br_eval     = 1'b0;
            end
            imem_valid = 1'b1;
            imem_rdata = data;
            step();
            imem_valid = 1'b0;
            exp_req  = 1'b0;
            exp_ir   = data;
            exp_pc   = exp_pc + 16'd1;
            exp_done = 1'b1;
            step();
            exp_done = 1'b0;
            lat = done_cyc - t0;
        end else begin
            for (int i = 1; i <= 15; i++) begin
                step();
                if (i == 15) begin
                    exp_req = 1'b0;
                    exp_err = 1'b1;
                end
            end
            step();
            exp_err = 1'b0;
            lat = -1;
        end
    endtask

    task automatic do_br(input logic [3:0] s);
        br_eval = 1'b1;
        stat    = s;
        step();
        br_eval = 1'b0;
        if (model_taken(exp_ir, s)) begin
            exp_pc    = model_target(exp_ir, exp_pc);
            exp_taken = 1'b1;
        end
        step();
        exp_taken = 1'b0;
    endtask

    task automatic do_br_and_fetch(input logic [3:0] s, input logic [31:0] data);
        br_eval     = 1'b1;
        fetch_start = 1'b1;
        stat        = s;
        step();
        br_eval     = 1'b0;
        fetch_start = 1'b0;
        if (model_taken(exp_ir, s)) begin
            exp_pc    = model_target(exp_ir, exp_pc);
            exp_taken = 1'b1;
        end
        step();
        exp_taken = 1'b0;
        exp_req   = 1'b1;
        exp_addr  = exp_pc;
        imem_valid = 1'b1;
        imem_rdata = data;
        step();
        imem_valid = 1'b0;
        exp_req  = 1'b0;
        exp_ir   = data;
        exp_pc   = exp_pc + 16'd1;
        exp_done = 1'b1;
        step();
        exp_done = 1'b0;
    endtask

    initial begin
        int lat;
        int tk0;
        int dn0;

        rst_f = 1'b0;
        repeat (3) step();
        check("reset_pc", 32'(pc), 32'h0);
        check("reset_ir", ir, 32'h0);
        check("reset_opcode", 32'(opcode), 32'h0);
        check("reset_req", 32'(imem_req), 32'h0);
        check("reset_pulses", {29'h0, fetch_done, br_taken, fetch_err}, 32'h0);
        rst_f  = 1'b1;
        chk_en = 1'b1;

        // Stray valid in IDLE and a branch eval on NOOP do nothing
        imem_valid = 1'b1;
        step();
        imem_valid = 1'b0;
        do_br(4'hF);

        // First fetch: latency 3
        do_fetch(32'h8000_0001, 0, 1'b1, 1'b0, lat);
        check("first_latency", lat, 32'd3);
        check("first_addr", 32'(seen_addr), 32'h0);
        check("first_ir", ir, 32'h8000_0001);
        check("first_opcode", 32'(opcode), 32'd8);
        check("first_pc", 32'(pc), 32'h1);

        // BRA mm=0 taken
        do_fetch(32'h4000_0020, 1, 1'b1, 1'b0, lat);
        tk0 = taken_cnt;
        do_br(4'h0);
        check("bra_pc", 32'(pc), 32'h0020);
        check("bra_taken_pulses", taken_cnt - tk0, 32'd1);

        // BRA mm=1 stat=0 not taken; fetch carries stray ctrl pulses and early valid
        do_fetch(32'h4100_0020, 2, 1'b1, 1'b1, lat);
        check("noise_pc", 32'(pc), 32'h0021);
        tk0 = taken_cnt;
        do_br(4'h0);
        check("bra_nt_pc", 32'(pc), 32'h0021);
        check("bra_nt_taken", taken_cnt - tk0, 32'd0);

        // BNR to pc-16 from 0x0010
        do_fetch(32'h4000_000F, 0, 1'b1, 1'b0, lat);
        do_br(4'h0);
        do_fetch(32'h7100_FFF0, 0, 1'b1, 1'b0, lat);
        check("bnr_start_pc", 32'(pc), 32'h0010);
        do_br(4'h1);
        check("bnr_nt_pc", 32'(pc), 32'h0010);
        do_br(4'h0);
        check("bnr_pc", 32'(pc), 32'h0000);

        // PC wrap on fetch increment
        do_fetch(32'h4000_FFFF, 0, 1'b1, 1'b0, lat);
        do_br(4'h0);
        check("wrap_start_pc", 32'(pc), 32'hFFFF);
        do_fetch(32'h1234_5678, 2, 1'b1, 1'b0, lat);
        check("wrap_pc", 32'(pc), 32'h0000);
        check("wrap_latency", lat, 32'd5);
        check("wrap_no_err", err_cnt, 32'd0);

        // Memory timeout, then retry at the same address
        dn0 = done_cnt;
        do_fetch(32'h0, 0, 1'b0, 1'b0, lat);
        check("to_err", err_cnt, 32'd1);
        check("to_no_done", done_cnt - dn0, 32'd0);
        check("to_pc", 32'(pc), 32'h0000);
        check("to_ir", ir, 32'h1234_5678);
        seen_addr = 16'hAAAA;
        do_fetch(32'h5200_0005, 0, 1'b1, 1'b0, lat);
        check("retry_addr", 32'(seen_addr), 32'h0000);

        // BRR on N flag: 1 + 5
        do_br(4'h2);
        check("brr_pc", 32'(pc), 32'h0006);

        // BNE on C flag
        do_fetch(32'h6800_0100, 0, 1'b1, 1'b0, lat);
        do_br(4'h8);
        check("bne_nt_pc", 32'(pc), 32'h0007);
        do_br(4'h0);
        check("bne_pc", 32'(pc), 32'h0100);

        // HLT is not a branch here
        do_fetch(32'hF000_0000, 0, 1'b1, 1'b0, lat);
        do_br(4'h0);
        check("hlt_pc", 32'(pc), 32'h0101);

        // Branch and fetch together: fetch uses the redirected PC
        do_fetch(32'h4000_0200, 0, 1'b1, 1'b0, lat);
        do_br_and_fetch(4'h0, 32'h8000_0002);
        check("combo_addr", 32'(seen_addr), 32'h0200);
        check("combo_pc", 32'(pc), 32'h0201);

        // Reset in the middle of WAIT
        dn0 = done_cnt;
        fetch_start = 1'b1;
        step();
        fetch_start = 1'b0;
        step();
        exp_req  = 1'b1;
        exp_addr = exp_pc;
        step();
        #2;
        rst_f = 1'b0;
        exp_pc  = 16'h0000;
        exp_ir  = 32'h0;
        exp_req = 1'b0;
        #1;
        check("rst_req_now", 32'(imem_req), 32'h0);
        check("rst_pc_now", 32'(pc), 32'h0);
        check("rst_ir_now", ir, 32'h0);
        step();
        rst_f      = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'h9999_9999;
        step();
        imem_valid = 1'b0;
        repeat (3) step();
        check("rst_no_done", done_cnt - dn0, 32'd0);
        check("rst_ir_after", ir, 32'h0);
        check("rst_pc_after", 32'(pc), 32'h0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
